exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-003 exKeep  in  1  hold the EXE/MEM latch, for example while the memory stage is busy.
REQ-004 rdata1_in, rdata2_in, imme_in, pc_in  in  16 each  operands, immediate and PC+1 from the ID/EXE latch.
REQ-005 wreg_in, rreg1_in, rreg2_in  in  4 each  destination and source register ids; 4'b1111 = none.
REQ-006 aluop_in  in  4; controlb_in  in  2; ifjump_in  in  1; jorb_in  in  2; controlmem_in  in  2; controlwb_in  in  1.
REQ-007 wb_wreg_in  in  4; wb_wdata_in  in  16  write-back stage destination and data, used for forwarding.
REQ-008 result_out, wdata_out  out  16 each  latched ALU result and store data.
REQ-009 wreg_out  out  4; controlmem_out  out  2; controlwb_out  out  1  latched controls.
REQ-010 stall_out  out  1  load-use stall request to IF/ID and ID/EXE (their Keep inputs).
REQ-011 branch_taken  out  1; branch_target  out  16  combinational redirect.

Function
REQ-012 controlmem encoding: 00 = load, 01 = store, 11 = none; 10 is treated as none.
REQ-013 Forwarding of operand A (rreg1) and of rdata2 (rreg2) is decided independently, in this priority order:
- own latch result_out, when wreg_out equals the source id, the id is not 1111, and controlmem_out is not load;
- then wb_wdata_in, when wb_wreg_in equals the source id and the id is not 1111;
- otherwise the register file data.
REQ-014 Operand B selection by controlb: 00 = forwarded rdata2, 01 = imme_in, 10 = pc_in, 11 = 16'h0000.
REQ-015 aluop encoding, all arithmetic 16-bit wrap-around with no flags:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A;
- 6 SLL, 7 SRL, 8 SRA, each shifting by B[3:0] with amount 0 meaning 8;
- 9 SLT signed giving 1/0, 10 SLTU giving 1/0, 11 CMP giving 0 if A==B else 1;
- 12 pass A, 13 pass B, 14-15 give 0.
REQ-016 Branch resolution by jorb:
- 00: none;
- 01: taken if forwarded A == 0;
- 10: taken if forwarded A != 0;
- 11: always taken.
REQ-017 branch_target is forwarded A when ifjump_in = 1, else pc_in + imme_in (mod 2^16); branch_taken is forced to 0 while stall_out = 1.
REQ-018 Load-use hazard exists when all of the following hold:
- controlmem_out == 00 and wreg_out != 1111;
- wreg_out equals rreg1_in, or equals rreg2_in with controlb_in == 00 or controlmem_in == 01.
REQ-019 Two-state FSM:
- RUN: on hazard, go to BUBBLE;
- BUBBLE: unconditionally return to RUN;
- stall_out is combinational: high in RUN while the hazard holds, low in BUBBLE.
REQ-020 Latch update on each rising edge, in priority order:
- rst;
- else exKeep = 1: hold all outputs and FSM state;
- else stall_out = 1: load a bubble (wreg_out = 1111, controlmem_out = 11, controlwb_out = 0; result_out and wdata_out unchanged);
- else capture ALU result, forwarded rdata2 as wdata_out, wreg_in, controlmem_in, controlwb_in.
REQ-021 Latency: one cycle from operands to result_out; branch_taken appears in the same cycle the branch is in EXE.
REQ-022 Simultaneous exKeep and hazard: exKeep wins, FSM holds state, stall_out stays asserted.

Reset
REQ-023 On rst, all of the following take effect at the next edge regardless of exKeep:
- wreg_out = 4'b1111, controlmem_out = 2'b11, controlwb_out = 0;
- result_out = 0, wdata_out = 0;
- FSM = RUN.
REQ-024 rst asserted in BUBBLE returns the FSM to RUN; any pending stall is dropped.

Verification
REQ-025 ADD with A = 16'h7FFF and B = imme 16'h0001 (controlb 01) -> result_out = 16'h8000 after one edge.
REQ-026 Back-to-back: ADD to r2, then SUB reading r2 -> EX/MEM forward; result correct with no stall_out.
REQ-027 Load to r3, next instruction reads r3:
- stall_out = 1 for exactly one cycle;
- bubble latched (wreg_out = 1111, controlmem_out = 11);
- next cycle operand taken from wb_wdata_in.
REQ-028 BEQZ with forwarded A = 0, pc_in = 16'h0010, imme = 16'hFFFE -> branch_taken = 1, branch_target = 16'h000E; with A = 1 -> branch_taken = 0.
REQ-029 exKeep = 1 for 3 cycles with changing inputs -> all outputs frozen; rst during exKeep -> reset values at the next edge.
REQ-030 SRA with A = 16'h8000 and B[3:0] = 0 -> result_out = 16'hFF80.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, load-use stall
// and the EXE/MEM pipeline latch.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exKeep,
    input  logic [15:0] rdata1_in,
    input  logic [15:0] rdata2_in,
    input  logic [15:0] imme_in,
    input  logic [15:0] pc_in,
    input  logic [3:0]  wreg_in,
    input  logic [3:0]  rreg1_in,
    input  logic [3:0]  rreg2_in,
    input  logic [3:0]  aluop_in,
    input  logic [1:0]  controlb_in,
    input  logic        ifjump_in,
    input  logic [1:0]  jorb_in,
    input  logic [1:0]  controlmem_in,
    input  logic        controlwb_in,
    input  logic [3:0]  wb_wreg_in,
    input  logic [15:0] wb_wdata_in,
    output logic [15:0] result_out,
    output logic [15:0] wdata_out,
    output logic [3:0]  wreg_out,
    output logic [1:0]  controlmem_out,
    output logic        controlwb_out,
    output logic        stall_out,
    output logic        branch_taken,
    output logic [15:0] branch_target
);
    localparam logic [3:0] REG_NONE = 4'b1111;
    localparam logic [1:0] MEM_LOAD = 2'b00;
    localparam logic [1:0] MEM_STORE = 2'b01;
    localparam logic [1:0] MEM_NONE = 2'b11;

    typedef enum logic {RUN, BUBBLE} state_t;
    state_t state;

    logic [15:0] opa, fwd2, opb, alu_res;
    logic [4:0]  sh;
    logic        hazard, take;

    // A load result is not available yet in our own latch, so it never forwards from there.
    always_comb begin
        opa = rdata1_in;
        if (rreg1_in != REG_NONE && wreg_out == rreg1_in && controlmem_out != MEM_LOAD)
            opa = result_out;
        else if (rreg1_in != REG_NONE && wb_wreg_in == rreg1_in)
            opa = wb_wdata_in;
        fwd2 = rdata2_in;
        if (rreg2_in != REG_NONE && wreg_out == rreg2_in && controlmem_out != MEM_LOAD)
            fwd2 = result_out;
        else if (rreg2_in != REG_NONE && wb_wreg_in == rreg2_in)
            fwd2 = wb_wdata_in;
    end

    always_comb begin
        case (controlb_in)
            2'b00:   opb = fwd2;
            2'b01:   opb = imme_in;
            2'b10:   opb = pc_in;
            default: opb = 16'h0000;
        endcase
    end

    // Shift amount field of zero encodes a shift by 8.
    assign sh = (opb[3:0] == 4'd0) ? 5'd8 : {1'b0, opb[3:0]};

    always_comb begin
        case (aluop_in)
            4'd0:    alu_res = opa + opb;
            4'd1:    alu_res = opa - opb;
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = ~opa;
            4'd6:    alu_res = opa << sh;
            4'd7:    alu_res = opa >> sh;
            4'd8:    alu_res = $signed(opa) >>> sh;
            4'd9:    alu_res = {15'd0, $signed(opa) < $signed(opb)};
            4'd10:   alu_res = {15'd0, opa < opb};
            4'd11:   alu_res = {15'd0, opa != opb};
            4'd12:   alu_res = opa;
            4'd13:   alu_res = opb;
            default: alu_res = 16'h0000;
        endcase
    end

    assign hazard = (controlmem_out == MEM_LOAD) && (wreg_out != REG_NONE) &&
                    ((wreg_out == rreg1_in) ||
                     (wreg_out == rreg2_in && (controlb_in == 2'b00 || controlmem_in == MEM_STORE)));
    assign stall_out = (state == RUN) && hazard;

    always_comb begin
        case (jorb_in)
            2'b01:   take = (opa == 16'h0000);
            2'b10:   take = (opa != 16'h0000);
            2'b11:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    assign branch_taken  = take && !stall_out;
    assign branch_target = ifjump_in ? opa : pc_in + imme_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            result_out     <= 16'h0000;
            wdata_out      <= 16'h0000;
            wreg_out       <= REG_NONE;
            controlmem_out <= MEM_NONE;
            controlwb_out  <= 1'b0;
        end else if (!exKeep) begin
            if (stall_out) begin
                state          <= BUBBLE;
                wreg_out       <= REG_NONE;
                controlmem_out <= MEM_NONE;
                controlwb_out  <= 1'b0;
            end else begin
                state          <= RUN;
                result_out     <= alu_res;
                wdata_out      <= fwd2;
                wreg_out       <= wreg_in;
                controlmem_out <= controlmem_in;
                controlwb_out  <= controlwb_in;
            end
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed spec scenarios then random traffic,
// predicted by an instruction-level reference model.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst, exKeep, ifjump_in, controlwb_in;
    logic [15:0] rdata1_in, rdata2_in, imme_in, pc_in, wb_wdata_in;
    logic [3:0]  wreg_in, rreg1_in, rreg2_in, aluop_in, wb_wreg_in;
    logic [1:0]  controlb_in, jorb_in, controlmem_in;
    logic [15:0] result_out, wdata_out, branch_target;
    logic [3:0]  wreg_out;
    logic [1:0]  controlmem_out;
    logic        controlwb_out, stall_out, branch_taken;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .exKeep(exKeep),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imme_in(imme_in), .pc_in(pc_in),
        .wreg_in(wreg_in), .rreg1_in(rreg1_in), .rreg2_in(rreg2_in), .aluop_in(aluop_in),
        .controlb_in(controlb_in), .ifjump_in(ifjump_in), .jorb_in(jorb_in),
        .controlmem_in(controlmem_in), .controlwb_in(controlwb_in),
        .wb_wreg_in(wb_wreg_in), .wb_wdata_in(wb_wdata_in),
        .result_out(result_out), .wdata_out(wdata_out), .wreg_out(wreg_out),
        .controlmem_out(controlmem_out), .controlwb_out(controlwb_out),
        .stall_out(stall_out), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    typedef struct {
        logic rst, keep, ij, cwb;
        logic [15:0] r1, r2, imm, pc, wbd;
        logic [3:0] wreg, rr1, rr2, op, wbw;
        logic [1:0] cb, jorb, cm;
    } in_t;

    typedef struct {
        logic [15:0] res, wd, tgt;
        logic [3:0] wreg;
        logic [1:0] cm;
        logic cwb, stall, br;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;

    // Architectural view of the EXE/MEM latch plus "previous cycle was stalled".
    logic [15:0] m_res, m_wd;
    logic [3:0]  m_wreg;
    logic [1:0]  m_cm;
    logic        m_cwb, m_after;

    function automatic logic [15:0] fwd(input logic [3:0] id, input logic [15:0] rf, input in_t t);
        if (id != 4'hF && id == m_wreg && m_cm != 2'b00) return m_res;
        if (id != 4'hF && id == t.wbw) return t.wbd;
        return rf;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sh, sa, sb;
        sh = (b % 16 == 0) ? 8 : b % 16;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~a;
            6: return 16'((int'(a) * (1 << sh)) % 65536);
            7: return 16'(int'(a) / (1 << sh));
            8: return 16'(sa >>> sh);
            9: return (sa < sb) ? 16'd1 : 16'd0;
            10: return (a < b) ? 16'd1 : 16'd0;
            11: return (a == b) ? 16'd0 : 16'd1;
            12: return a;
            13: return b;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_res = 0; m_wd = 0; m_wreg = 4'hF; m_cm = 2'b11; m_cwb = 0; m_after = 0;
    endtask

    task automatic drive(input in_t t);
        rst = t.rst; exKeep = t.keep; rdata1_in = t.r1; rdata2_in = t.r2; imme_in = t.imm;
        pc_in = t.pc; wreg_in = t.wreg; rreg1_in = t.rr1; rreg2_in = t.rr2; aluop_in = t.op;
        controlb_in = t.cb; ifjump_in = t.ij; jorb_in = t.jorb; controlmem_in = t.cm;
        controlwb_in = t.cwb; wb_wreg_in = t.wbw; wb_wdata_in = t.wbd;
    endtask

    task automatic issue(input in_t t);
        logic [15:0] fa, f2, b;
        logic haz, stall, take;
        exp_t e;
        @(posedge clk); #1;
        drive(t);
        #1;
        fa = fwd(t.rr1, t.r1, t);
        f2 = fwd(t.rr2, t.r2, t);
        b = (t.cb == 0) ? f2 : (t.cb == 1) ? t.imm : (t.cb == 2) ? t.pc : 16'h0;
        haz = m_cm == 2'b00 && m_wreg != 4'hF &&
              (m_wreg == t.rr1 || (m_wreg == t.rr2 && (t.cb == 0 || t.cm == 2'b01)));
        stall = haz && !m_after;
        take = (t.jorb == 1 && fa == 0) || (t.jorb == 2 && fa != 0) || t.jorb == 3;
        e.res = m_res; e.wd = m_wd; e.wreg = m_wreg; e.cm = m_cm; e.cwb = m_cwb;
        e.stall = stall; e.br = take && !stall; e.tgt = t.ij ? fa : t.pc + t.imm;
        sbq.push_back(e);
        if (t.rst) model_reset();
        else if (!t.keep) begin
            if (stall) begin
                m_wreg = 4'hF; m_cm = 2'b11; m_cwb = 0; m_after = 1;
            end else begin
                m_res = ref_alu(t.op, fa, b); m_wd = f2; m_wreg = t.wreg;
                m_cm = t.cm; m_cwb = t.cwb; m_after = 0;
            end
        end
    endtask

    function automatic in_t nop();
        in_t t;
        t.rst = 0; t.keep = 0; t.ij = 0; t.cwb = 0; t.r1 = 0; t.r2 = 0; t.imm = 0; t.pc = 0;
        t.wbd = 0; t.wreg = 4'hF; t.rr1 = 4'hF; t.rr2 = 4'hF; t.op = 0; t.wbw = 4'hF;
        t.cb = 2'b11; t.jorb = 0; t.cm = 2'b11;
        return t;
    endfunction

    function automatic in_t rnd();
        in_t t;
        logic [3:0] ids [4] = '{4'd1, 4'd2, 4'd3, 4'hF};
        t.rst = ($urandom_range(0, 39) == 0); t.keep = ($urandom_range(0, 5) == 0);
        t.ij = 1'($urandom); t.cwb = 1'($urandom);
        t.r1 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        t.r2 = 16'($urandom); t.imm = 16'($urandom); t.pc = 16'($urandom); t.wbd = 16'($urandom);
        t.wreg = ids[$urandom_range(0, 3)]; t.rr1 = ids[$urandom_range(0, 3)];
        t.rr2 = ids[$urandom_range(0, 3)]; t.wbw = ids[$urandom_range(0, 3)];
        t.op = 4'($urandom); t.cb = 2'($urandom); t.jorb = 2'($urandom); t.cm = 2'($urandom);
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("result_out", result_out, e.res);
                chk("wdata_out", wdata_out, e.wd);
                chk("wreg_out", {12'd0, wreg_out}, {12'd0, e.wreg});
                chk("controlmem_out", {14'd0, controlmem_out}, {14'd0, e.cm});
                chk("controlwb_out", {15'd0, controlwb_out}, {15'd0, e.cwb});
                chk("stall_out", {15'd0, stall_out}, {15'd0, e.stall});
                chk("branch_taken", {15'd0, branch_taken}, {15'd0, e.br});
                chk("branch_target", branch_target, e.tgt);
            end
        end
    end

    initial begin : driver
        in_t t;
        int wait_cyc;
        t = nop(); t.rst = 1; drive(t);
        repeat (2) @(posedge clk);
        model_reset();
        issue(t);                                   // reset state observed
        t = nop(); t.op = 0; t.r1 = 16'h7FFF; t.cb = 2'b01; t.imm = 16'h0001; issue(t);
        t = nop(); t.op = 8; t.r1 = 16'h8000; t.cb = 2'b11; issue(t);
        t = nop(); t.op = 0; t.wreg = 2; t.cwb = 1; t.r1 = 16'h0030; t.cb = 2'b01; t.imm = 16'h0005; issue(t);
        t = nop(); t.op = 1; t.rr1 = 2; t.r1 = 16'hDEAD; t.cb = 2'b01; t.imm = 16'h0001; t.wreg = 4; issue(t);
        t = nop(); t.cm = 2'b00; t.wreg = 3; t.cwb = 1; issue(t);
        t = nop(); t.op = 0; t.rr1 = 3; t.r1 = 16'h1111; t.cb = 2'b01; t.imm = 16'h0002; t.wreg = 5; issue(t);
        t.wbw = 3; t.wbd = 16'h0400; issue(t);
        t = nop(); t.jorb = 2'b01; t.pc = 16'h0010; t.imm = 16'hFFFE; t.r1 = 16'h0000; issue(t);
        t.r1 = 16'h0001; issue(t);
        t = nop(); t.jorb = 2'b11; t.ij = 1; t.r1 = 16'h1234; issue(t);
        for (int i = 0; i < 3; i++) begin
            t = rnd(); t.rst = 0; t.keep = 1; issue(t);
        end
        t = rnd(); t.rst = 1; t.keep = 1; issue(t);
        t = nop(); t.cm = 2'b00; t.wreg = 3; issue(t);
        t = nop(); t.rr2 = 3; t.cb = 2'b00; t.keep = 1; t.jorb = 2'b11; issue(t);
        issue(t);
        t.keep = 0; issue(t);
        t = nop(); t.cm = 2'b00; t.wreg = 3; issue(t);
        t = nop(); t.rr2 = 3; t.cm = 2'b01; t.cb = 2'b01; issue(t);
        t.rst = 1; issue(t);
        t = nop(); issue(t);
        for (int i = 0; i < 500; i++) issue(rnd());
        wait_cyc = 0;
        while (sbq.size() > 0 && wait_cyc < 20) begin
            @(posedge clk); wait_cyc++;
        end
        @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
